// File: rtl/plic_gateway_pkg.sv
// Shared types and default widths for the PLIC gateway and core.
package plic_pkg;

  localparam int unsigned DEF_SOURCES     = 5;
  localparam int unsigned DEF_ID_W        = 3;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 2;

  localparam int unsigned NO_ID = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PENDING    = 2'b01,
    IN_SERVICE = 2'b10
  } gw_state_e;

endpackage

// File: rtl/plic_gateway_if.sv
// Core-facing handshake between the PLIC core and the gateway array.
interface plic_gateway_if
  import plic_pkg::*;
#(
  parameter int unsigned Number_of_Sources = DEF_SOURCES,
  parameter int unsigned Interrupt_Width   = DEF_ID_W
);

  logic                         set_IP;
  logic                         clear_IP;
  logic [Interrupt_Width-1:0]   Claim_ID;
  logic                         Complete_valid;
  logic [Interrupt_Width-1:0]   Complete_ID;
  logic [Number_of_Sources-1:0] Interrupt_Request;
  logic [Number_of_Sources-1:0] IP_interrupt;
  logic [Number_of_Sources-1:0] In_Service;

  modport slave (
    input  set_IP, clear_IP, Claim_ID, Complete_valid, Complete_ID,
    output Interrupt_Request, IP_interrupt, In_Service
  );

  modport master (
    output set_IP, clear_IP, Claim_ID, Complete_valid, Complete_ID,
    input  Interrupt_Request, IP_interrupt, In_Service
  );

endinterface

// File: rtl/plic_gateway_cell.sv
// One interrupt source: synchronizer, edge counter and claim/complete FSM.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic edge_mode,
  input  logic set_ip,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic req,
  output logic ip,
  output logic in_service
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   prev_q;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  gw_state_e              state_q, state_d;
  logic                   take;
  logic                   inc;
  logic                   dec;

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~prev_q;

  assign req        = (state_q == IDLE) & (edge_mode ? (cnt_q != '0) : s);
  assign take       = req & set_ip;
  assign ip         = (state_q == PENDING);
  assign in_service = (state_q == IN_SERVICE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_q  <= s;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // A saturated counter still absorbs an edge when a request is taken in the same cycle.
    inc     = edge_det & ((cnt_q != '1) | take);
    dec     = take & edge_mode;

    case (state_q)
      IDLE:       if (take)         state_d = PENDING;
      PENDING:    if (claim_hit)    state_d = IN_SERVICE;
      IN_SERVICE: if (complete_hit) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase

    if (!edge_mode) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/plic_gateway.sv
// Array of per-source gateway cells with claim/complete ID decode.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned Number_of_Sources = DEF_SOURCES,
  parameter int unsigned Interrupt_Width   = DEF_ID_W,
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W             = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [Number_of_Sources-1:0] irq_src,
  input  logic [Number_of_Sources-1:0] edge_mode,
  plic_gateway_if.slave                bus
);

  logic [Number_of_Sources-1:0] req_v;
  logic [Number_of_Sources-1:0] ip_v;
  logic [Number_of_Sources-1:0] is_v;
  logic [Number_of_Sources-1:0] claim_hit;
  logic [Number_of_Sources-1:0] complete_hit;

  for (genvar k = 0; k < Number_of_Sources; k++) begin : g_src
    // Source k answers to ID k+1, so ID 0 and IDs past the last source match nothing.
    assign claim_hit[k]    = bus.clear_IP && (int'(bus.Claim_ID) != NO_ID)
                             && (int'(bus.Claim_ID) == k + 1);
    assign complete_hit[k] = bus.Complete_valid && (int'(bus.Complete_ID) != NO_ID)
                             && (int'(bus.Complete_ID) == k + 1);

    plic_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq          (irq_src[k]),
      .edge_mode    (edge_mode[k]),
      .set_ip       (bus.set_IP),
      .claim_hit    (claim_hit[k]),
      .complete_hit (complete_hit[k]),
      .req          (req_v[k]),
      .ip           (ip_v[k]),
      .in_service   (is_v[k])
    );
  end

  assign bus.Interrupt_Request = req_v;
  assign bus.IP_interrupt      = ip_v;
  assign bus.In_Service        = is_v;

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: level/edge triggering, claim/complete rules, reset.
module tb_plic_gateway;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] irq_src;
  logic [4:0] edge_mode;

  int checks = 0;
  int errors = 0;

  plic_gateway_if #(.Number_of_Sources(5), .Interrupt_Width(3)) bus ();

  plic_gateway #(
    .Number_of_Sources (5),
    .Interrupt_Width   (3),
    .SYNC_STAGES       (2),
    .CNT_W             (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .edge_mode (edge_mode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] irq;
    logic       set;
    logic       clr;
    logic [2:0] cid;
    logic       cv;
    logic [2:0] pid;
    logic [4:0] exp_req;
    logic [4:0] exp_ip;
    logic [4:0] exp_is;
  } vec_t;

  vec_t vecs[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [4:0] r, input logic [4:0] p,
                         input logic [4:0] s);
    chk({name, " req"}, bus.Interrupt_Request, r);
    chk({name, " ip"},  bus.IP_interrupt,      p);
    chk({name, " is"},  bus.In_Service,        s);
  endtask

  task automatic idle_bus();
    bus.set_IP         = 1'b0;
    bus.clear_IP       = 1'b0;
    bus.Claim_ID       = 3'd0;
    bus.Complete_valid = 1'b0;
    bus.Complete_ID    = 3'd0;
  endtask

  // One rising pulse on irq_src[k], long enough to clear the synchronizer both ways.
  task automatic pulse(input int k);
    irq_src[k] = 1'b1;
    step();
    step();
    irq_src[k] = 1'b0;
    step();
    step();
  endtask

  task automatic claim(input logic [2:0] id);
    bus.clear_IP = 1'b1;
    bus.Claim_ID = id;
    step();
    bus.clear_IP = 1'b0;
    bus.Claim_ID = 3'd0;
  endtask

  task automatic complete(input logic [2:0] id);
    bus.Complete_valid = 1'b1;
    bus.Complete_ID    = id;
    step();
    bus.Complete_valid = 1'b0;
    bus.Complete_ID    = 3'd0;
  endtask

  task automatic set_ip_once();
    bus.set_IP = 1'b1;
    step();
    bus.set_IP = 1'b0;
  endtask

  initial begin
    int served;

    //            irq      set  clr  cid   cv   pid   req       ip        is
    vecs[0]  = '{5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    vecs[1]  = '{5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00001, 5'b00000, 5'b00000};
    vecs[2]  = '{5'b00001, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    vecs[3]  = '{5'b00001, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    vecs[4]  = '{5'b00001, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    vecs[5]  = '{5'b00001, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    vecs[6]  = '{5'b00001, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b00001};
    vecs[7]  = '{5'b00001, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 5'b00001, 5'b00000, 5'b00000};
    vecs[8]  = '{5'b00001, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    vecs[9]  = '{5'b01001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    vecs[10] = '{5'b01001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 5'b01000, 5'b00001, 5'b00000};
    vecs[11] = '{5'b01001, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b01001, 5'b00000};
    vecs[12] = '{5'b01001, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 5'b00000, 5'b01001, 5'b00000};
    vecs[13] = '{5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b01001, 5'b00000};
    vecs[14] = '{5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b01001, 5'b00000};
    vecs[15] = '{5'b00000, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4, 5'b00000, 5'b00001, 5'b01000};
    vecs[16] = '{5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 5'b00000, 5'b00001, 5'b00000};
    vecs[17] = '{5'b00000, 1'b0, 1'b1, 3'd1, 1'b1, 3'd1, 5'b00000, 5'b00000, 5'b00001};
    vecs[18] = '{5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 5'b00000, 5'b00000, 5'b00000};

    rst_n     = 1'b1;
    irq_src   = '0;
    edge_mode = '0;
    idle_bus();
    step();
    step();
    chk_all("reset", 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b0;

    // Level-mode claim/complete rules, one cycle per vector.
    for (int i = 0; i < 19; i++) begin
      irq_src            = vecs[i].irq;
      bus.set_IP         = vecs[i].set;
      bus.clear_IP       = vecs[i].clr;
      bus.Claim_ID       = vecs[i].cid;
      bus.Complete_valid = vecs[i].cv;
      bus.Complete_ID    = vecs[i].pid;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_ip, vecs[i].exp_is);
    end
    idle_bus();
    irq_src = '0;
    step();

    // Edge mode: four edges while in service saturate the count at three.
    edge_mode = 5'b00100;
    pulse(2);
    chk("edge first req", bus.Interrupt_Request, 5'b00100);
    set_ip_once();
    chk("edge pending", bus.IP_interrupt, 5'b00100);
    claim(3'd3);
    chk("edge claimed", bus.In_Service, 5'b00100);
    for (int i = 0; i < 4; i++) pulse(2);
    chk("edge no req in service", bus.Interrupt_Request, 5'b00000);
    complete(3'd3);
    served = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Interrupt_Request[2]) begin
        served++;
        set_ip_once();
        claim(3'd3);
        complete(3'd3);
      end
    end
    chk("edge served count", 5'(served), 5'd3);
    chk("edge drained req", bus.Interrupt_Request, 5'b00000);

    // Edge coinciding with IDLE->PENDING while cnt=1 leaves cnt at 1.
    pulse(2);
    chk("coinc cnt1 req", bus.Interrupt_Request, 5'b00100);
    irq_src[2] = 1'b1;
    step();
    step();
    bus.set_IP = 1'b1;
    step();
    bus.set_IP = 1'b0;
    irq_src[2] = 1'b0;
    chk("coinc pending", bus.IP_interrupt, 5'b00100);
    step();
    step();
    claim(3'd3);
    complete(3'd3);
    chk("coinc leftover req", bus.Interrupt_Request, 5'b00100);
    set_ip_once();
    chk("coinc second pending", bus.IP_interrupt, 5'b00100);
    claim(3'd3);
    complete(3'd3);
    chk("coinc drained", bus.Interrupt_Request, 5'b00000);

    // Reset mid-operation with src0 pending and src2 in service holding cnt=2.
    irq_src[0] = 1'b1;
    pulse(2);
    set_ip_once();
    claim(3'd3);
    pulse(2);
    pulse(2);
    chk("pre-rst ip", bus.IP_interrupt, 5'b00001);
    chk("pre-rst is", bus.In_Service, 5'b00100);
    rst_n = 1'b1;
    step();
    chk_all("mid-rst", 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b0;
    step();
    chk("post-rst 1 edge", bus.Interrupt_Request, 5'b00000);
    step();
    chk("post-rst 2 edges", bus.Interrupt_Request, 5'b00001);
    chk("post-rst ip", bus.IP_interrupt, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
